// File: rtl/sm3_pkg.sv
// Shared types and sizes for the SM3 message block reader.
// Word 0 of a block is the most significant 64 bits.
package sm3_pkg;

    localparam int SM3_FIFO_W    = 64;
    localparam int SM3_BLK_WORDS = 8;
    localparam int SM3_BLK_W     = 512;

    typedef enum logic {
        ST_FILL,
        ST_HOLD
    } sm3_rd_state_e;

    typedef logic [0:SM3_BLK_WORDS-1][SM3_FIFO_W-1:0] sm3_block_t;

endpackage

// File: rtl/sm3_block_reader_if.sv
// FIFO read side and block handshake of the SM3 block reader.
// master = reader, slave = FIFO plus compression core.
interface sm3_block_reader_if;

    logic [sm3_pkg::SM3_FIFO_W-1:0] fifo_dout_i;
    logic                           fifo_last_i;
    logic                           fifo_empty_i;
    logic                           fifo_rena_o;
    logic [sm3_pkg::SM3_BLK_W-1:0]  block_o;
    logic                           block_valid_o;
    logic                           block_last_o;
    logic [63:0]                    block_index_o;
    logic                           block_ready_i;
    logic                           err_o;

    modport master (
        input  fifo_dout_i, fifo_last_i, fifo_empty_i, block_ready_i,
        output fifo_rena_o, block_o, block_valid_o, block_last_o,
        output block_index_o, err_o
    );

    modport slave (
        output fifo_dout_i, fifo_last_i, fifo_empty_i, block_ready_i,
        input  fifo_rena_o, block_o, block_valid_o, block_last_o,
        input  block_index_o, err_o
    );

endinterface

// File: rtl/sm3_blk_buf.sv
// One 512-bit message block buffer: slot write port plus
// full/last/index registers captured when the block completes.
module sm3_blk_buf
    import sm3_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [2:0]            i_wr_slot,
    input  logic [SM3_FIFO_W-1:0] i_wr_data,
    input  logic                  i_set_full,
    input  logic                  i_last,
    input  logic [63:0]           i_idx,
    input  logic                  i_clr_full,
    output sm3_block_t            o_block,
    output logic                  o_full,
    output logic                  o_last,
    output logic [63:0]           o_idx
);

    sm3_block_t  r_block;
    logic        r_full;
    logic        r_last;
    logic [63:0] r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_block <= '0;
            r_full  <= 1'b0;
            r_last  <= 1'b0;
            r_idx   <= '0;
        end else begin
            if (i_wr_en) begin
                r_block[i_wr_slot] <= i_wr_data;
            end
            if (i_set_full) begin
                r_full <= 1'b1;
                r_last <= i_last;
                r_idx  <= i_idx;
            end else if (i_clr_full) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_block = r_block;
    assign o_full  = r_full;
    assign o_last  = r_last;
    assign o_idx   = r_idx;

endmodule

// File: rtl/sm3_block_reader.sv
// Packs FIFO words into 512-bit SM3 blocks with last flag and index.
// SM3_BLK_PINGPONG_EN: two buffers so reads overlap the hold phase.
module sm3_block_reader
    import sm3_pkg::*;
#(
    parameter int FIFO_RD_LAT = 1
) (
    input logic                clk,
    input logic                rst_n,
    sm3_block_reader_if.master bus
);

`ifdef SM3_BLK_PINGPONG_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    logic [FIFO_RD_LAT-1:0] r_pend;
    logic [2:0]             r_wr_cnt;
    logic [63:0]            r_nidx;
    logic                   r_err;

    logic w_rena;
    logic w_wr;
    logic w_done;
    logic w_mis;
    logic w_valid;
    logic w_xfer;

    logic [NBUF-1:0] w_wen;
    logic [NBUF-1:0] w_set;
    logic [NBUF-1:0] w_clr;
    logic [NBUF-1:0] w_full;
    logic [NBUF-1:0] w_last;
    sm3_block_t      w_blk [NBUF];
    logic [63:0]     w_idx [NBUF];

    sm3_block_t  w_out_blk;
    logic        w_out_last;
    logic [63:0] w_out_idx;

    assign w_wr   = r_pend[FIFO_RD_LAT-1];
    assign w_done = w_wr && (r_wr_cnt == 3'd7);
    assign w_mis  = w_wr && bus.fifo_last_i && (r_wr_cnt != 3'd7);
    assign w_xfer = w_valid && bus.block_ready_i;

    // r_nidx is the index the block now being filled will carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend   <= '0;
            r_wr_cnt <= '0;
            r_nidx   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_pend <= FIFO_RD_LAT'({r_pend, w_rena});
            if (w_mis) begin
                r_wr_cnt <= '0;
            end else if (w_wr) begin
                r_wr_cnt <= r_wr_cnt + 3'd1;
            end
            if (w_mis) begin
                r_err  <= 1'b1;
                r_nidx <= '0;
            end else if (w_done) begin
                r_nidx <= bus.fifo_last_i ? 64'd0 : r_nidx + 64'd1;
            end
        end
    end

    for (genvar i = 0; i < NBUF; i++) begin : g_buf
        sm3_blk_buf u_buf (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_wr_en    (w_wen[i]),
            .i_wr_slot  (r_wr_cnt),
            .i_wr_data  (bus.fifo_dout_i),
            .i_set_full (w_set[i]),
            .i_last     (bus.fifo_last_i),
            .i_idx      (r_nidx),
            .i_clr_full (w_clr[i]),
            .o_block    (w_blk[i]),
            .o_full     (w_full[i]),
            .o_last     (w_last[i]),
            .o_idx      (w_idx[i])
        );
    end

`ifdef SM3_BLK_PINGPONG_EN
    logic       r_wsel;
    logic       r_rsel;
    logic [4:0] w_cap;
    logic [4:0] w_used;

    // free slots across non-full buffers vs. words stored or in flight
    assign w_cap  = (w_full[0] ? 5'd0 : 5'd8) + (w_full[1] ? 5'd0 : 5'd8);
    assign w_used = {2'b00, r_wr_cnt} + {4'b0000, r_pend[0]};
    assign w_rena = !bus.fifo_empty_i && (w_cap > w_used);

    assign w_wen = {w_wr && r_wsel, w_wr && !r_wsel};
    assign w_set = {w_done && r_wsel, w_done && !r_wsel};
    assign w_clr = {w_xfer && r_rsel, w_xfer && !r_rsel};

    assign w_valid    = w_full[r_rsel];
    assign w_out_blk  = w_blk[r_rsel];
    assign w_out_last = w_last[r_rsel];
    assign w_out_idx  = w_idx[r_rsel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wsel <= 1'b0;
            r_rsel <= 1'b0;
        end else begin
            if (w_done) begin
                r_wsel <= ~r_wsel;
            end
            if (w_xfer) begin
                r_rsel <= ~r_rsel;
            end
        end
    end
`else
    sm3_rd_state_e r_state;
    logic [3:0]    r_issue_cnt;

    assign w_rena = (r_state == ST_FILL) && !bus.fifo_empty_i &&
                    (r_issue_cnt < 4'd8);

    assign w_wen = w_wr;
    assign w_set = w_done;
    assign w_clr = w_xfer;

    assign w_valid    = w_full[0];
    assign w_out_blk  = w_blk[0];
    assign w_out_last = w_last[0];
    assign w_out_idx  = w_idx[0];

    // a read issued alongside a misaligned word belongs to the new block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FILL;
            r_issue_cnt <= '0;
        end else begin
            unique case (r_state)
                ST_FILL: begin
                    if (w_done) begin
                        r_state     <= ST_HOLD;
                        r_issue_cnt <= '0;
                    end else if (w_mis) begin
                        r_issue_cnt <= {3'b000, w_rena};
                    end else if (w_rena) begin
                        r_issue_cnt <= r_issue_cnt + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (w_xfer) begin
                        r_state <= ST_FILL;
                    end
                end
            endcase
        end
    end
`endif

    assign bus.fifo_rena_o   = w_rena;
    assign bus.block_o       = w_out_blk;
    assign bus.block_valid_o = w_valid;
    assign bus.block_last_o  = w_out_last;
    assign bus.block_index_o = w_out_idx;
    assign bus.err_o         = r_err;

endmodule

// File: tb/tb_sm3_block_reader.sv
// Randomized bench for sm3_block_reader with a word-stream reference model.
// Define SM3_BLK_PINGPONG_EN to check the two-buffer build.
module tb_sm3_block_reader;
    import sm3_pkg::*;

`ifdef SM3_BLK_PINGPONG_EN
    localparam int BLK_PERIOD = 8;
`else
    localparam int BLK_PERIOD = 10;
`endif

    typedef struct {
        logic [SM3_BLK_W-1:0] blk;
        logic                 last;
        logic [63:0]          idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sm3_block_reader_if u_if ();

    sm3_block_reader #(.FIFO_RD_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int held = 0;
    int n_pops = 0;
    int rdy_mode = 0;
    int emp_mode = 0;

    logic [64:0] fifo_q [$];
    logic [63:0] cur [$];
    exp_t        exp_q [$];
    logic [63:0] m_nidx;
    logic        m_err;
    int          rena_cyc [$];
    int          rise_cyc [$];
    int          xfer_cyc [$];

    logic                 prev_valid;
    logic                 prev_xfer;
    logic [SM3_BLK_W-1:0] prev_blk;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // message grouping: 8 words per block, a short group ending in last is an error
    function automatic void model_push(input logic [64:0] w);
        exp_t e;
        cur.push_back(w[63:0]);
        if (w[64] && cur.size() < 8) begin
            m_err  = 1'b1;
            m_nidx = '0;
            cur.delete();
        end else if (cur.size() == 8) begin
            for (int i = 0; i < 8; i++) e.blk[511-64*i -: 64] = cur[i];
            e.last = w[64];
            e.idx  = m_nidx;
            m_nidx = w[64] ? 64'd0 : m_nidx + 64'd1;
            exp_q.push_back(e);
            cur.delete();
        end
    endfunction

    task automatic push_words(input int n, input int last_pos,
                              input logic [63:0] base, input bit rnd);
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? {$urandom(), $urandom()} : base + 64'(i);
            fifo_q.push_back({1'(i == last_pos), d});
        end
    endtask

    task automatic step();
        logic [64:0] w;
        bit          popped;
        bit          force_empty;
        exp_t        e;
        w = '0;
        popped = 0;
        @(negedge clk);
        if (u_if.fifo_rena_o)
            chk("rena_while_empty", 512'(u_if.fifo_empty_i), 512'(0));
        if (prev_valid && !prev_xfer) begin
            chk("hold_valid", 512'(u_if.block_valid_o), 512'(1));
            chk("hold_stable", u_if.block_o, prev_blk);
        end
`ifndef SM3_BLK_PINGPONG_EN
        if (u_if.block_valid_o)
            chk("read_in_hold", 512'(u_if.fifo_rena_o), 512'(0));
`endif
        if (u_if.block_valid_o && !prev_valid) rise_cyc.push_back(cyc);
        if (u_if.block_valid_o && u_if.block_ready_i) begin
            xfer_cyc.push_back(cyc);
            held = 0;
            if (exp_q.size() == 0) begin
                chk("unexpected_block", 512'(1), 512'(0));
            end else begin
                e = exp_q.pop_front();
                chk("block", u_if.block_o, e.blk);
                chk("block_last", 512'(u_if.block_last_o), 512'(e.last));
                chk("block_index", 512'(u_if.block_index_o), 512'(e.idx));
            end
        end
        if (u_if.fifo_rena_o && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            popped = 1;
            model_push(w);
            rena_cyc.push_back(cyc);
            n_pops++;
        end
        prev_valid = u_if.block_valid_o;
        prev_xfer  = u_if.block_valid_o && u_if.block_ready_i;
        prev_blk   = u_if.block_o;
        @(posedge clk);
        #1;
        cyc++;
        if (popped) begin
            u_if.fifo_dout_i = w[63:0];
            u_if.fifo_last_i = w[64];
        end else begin
            u_if.fifo_dout_i = {$urandom(), $urandom()};
            u_if.fifo_last_i = 1'($urandom());
        end
        case (emp_mode)
            1:       force_empty = (cyc % 2) == 1;
            2:       force_empty = ($urandom_range(0, 3) == 0);
            default: force_empty = 0;
        endcase
        u_if.fifo_empty_i = (fifo_q.size() == 0) || force_empty;
        case (rdy_mode)
            1: u_if.block_ready_i = 1'($urandom_range(0, 1));
            2: begin
                if (u_if.block_valid_o && held < 5) begin
                    u_if.block_ready_i = 1'b0;
                    held++;
                end else begin
                    u_if.block_ready_i = 1'b1;
                end
            end
            default: u_if.block_ready_i = 1'b1;
        endcase
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_budget", 512'(n < budget), 512'(1));
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fifo_q.delete();
        cur.delete();
        exp_q.delete();
        m_nidx = '0;
        m_err = 1'b0;
        prev_valid = 1'b0;
        prev_xfer = 1'b0;
        held = 0;
        u_if.fifo_empty_i = 1'b1;
        u_if.block_ready_i = 1'b0;
        @(negedge clk);
        chk("rst_rena", 512'(u_if.fifo_rena_o), 512'(0));
        chk("rst_valid", 512'(u_if.block_valid_o), 512'(0));
        chk("rst_last", 512'(u_if.block_last_o), 512'(0));
        chk("rst_index", 512'(u_if.block_index_o), 512'(0));
        chk("rst_err", 512'(u_if.err_o), 512'(0));
        chk("rst_block", u_if.block_o, 512'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int nb;
        u_if.fifo_dout_i   = '0;
        u_if.fifo_last_i   = 1'b0;
        u_if.fifo_empty_i  = 1'b1;
        u_if.block_ready_i = 1'b0;
        #2;
        do_reset();

        rdy_mode = 0;
        emp_mode = 0;
        rena_cyc.delete();
        rise_cyc.delete();
        push_words(8, 7, 64'd1, 0);
        drain(100);
        if (rena_cyc.size() >= 8 && rise_cyc.size() >= 1)
            chk("latency", 512'(rise_cyc[0] - rena_cyc[7]), 512'(2));
        else
            chk("latency_seen", 512'(0), 512'(1));
        chk("err_clean", 512'(u_if.err_o), 512'(m_err));

        rdy_mode = 2;
        push_words(16, 15, 64'h100, 0);
        drain(200);

        rdy_mode = 0;
        emp_mode = 1;
        push_words(24, 23, 64'h200, 0);
        drain(300);

        emp_mode = 0;
        push_words(4, 3, 64'h300, 0);
        push_words(8, 7, 64'h400, 0);
        drain(100);
        chk("err_set", 512'(u_if.err_o), 512'(m_err));

        rdy_mode = 1;
        emp_mode = 2;
        repeat (6) begin
            nb = $urandom_range(1, 3);
            push_words(8 * nb, 8 * nb - 1, 64'd0, 1);
        end
        drain(2000);
        chk("err_sticky", 512'(u_if.err_o), 512'(m_err));

        rdy_mode = 0;
        emp_mode = 0;
        xfer_cyc.delete();
        push_words(32, 31, 64'h500, 0);
        drain(200);
        if (xfer_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("block_spacing", 512'(xfer_cyc[i] - xfer_cyc[i-1]),
                    512'(BLK_PERIOD));
        end else begin
            chk("block_count", 512'(xfer_cyc.size()), 512'(4));
        end

        push_words(16, 15, 64'h600, 0);
        n_pops = 0;
        n = 0;
        while (n_pops < 5 && n < 50) begin
            step();
            n++;
        end
        chk("pops_before_reset", 512'(n_pops >= 5), 512'(1));
        do_reset();
        push_words(8, 7, 64'h700, 0);
        drain(100);
        chk("err_after_reset", 512'(u_if.err_o), 512'(m_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
